// File: rtl/cs_drv_pkg.sv
// Shared types and constants for the current-steering cell driver.
package cs_drv_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shifted towards the MSB.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int acc_w(input int w);
    return w + 2;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cs_cell_driver_sd_mod1.sv
// First-order sigma-delta core: accumulator and 1-bit decision, advanced on strobe.
module sd_mod1 import cs_drv_pkg::*; #(
  parameter int W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                strobe_i,
  input  logic signed [W-1:0] sample_i,
  input  logic                dith_i,
  output logic                bit_o
);

  localparam int AW = acc_w(W);
  localparam int FS = 1 << (W - 1);

  logic signed [AW-1:0] acc_q, acc_d, fb;

  // The decision is taken from the accumulator before this step's update.
  assign bit_o = ~acc_q[AW-1];

  always_comb begin
    fb    = bit_o ? AW'(FS) : -AW'(FS);
    acc_d = acc_q + AW'(sample_i) + AW'($signed({1'b0, dith_i})) - fb;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (strobe_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/cs_cell_driver.sv
// Sigma-delta driver for the current-steering cell with break-before-make dead time.
// Optional build macro CS_DRV_DITHER_EN adds a 1-LSB LFSR dither to the modulator input.
module cs_cell_driver import cs_drv_pkg::*; #(
  parameter int W        = 8,
  parameter int OSR      = 16,
  parameter int STEP_DIV = 4,
  parameter int DEAD_CYC = 1
) (
  input  logic                i_sys_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic signed [W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic                o_sample_ready,
  output logic                o_cs_cell_hi,
  output logic                o_cs_cell_lo,
  output logic                o_underrun
);

  localparam int PW = $clog2(STEP_DIV);
  localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  logic [PW-1:0]       presc_q;
  logic [SW-1:0]       step_q;
  logic                buf_full_q, buf_full_d, underrun_q;
  logic signed [W-1:0] buf_q, cur_q, mod_sample;
  state_t              state_q, target_q;
  logic [DW-1:0]       dead_q;
  logic                hi_q, lo_q;
  logic                strobe, blk_start, xfer, load, mod_bit, dith;

  assign strobe     = i_enable && (presc_q == PW'(STEP_DIV - 1));
  assign blk_start  = strobe && (step_q == '0);
  assign xfer       = i_sample_valid && !buf_full_q;
  assign load       = blk_start && buf_full_q;
  assign buf_full_d = (buf_full_q && !load) || xfer;
  // The block-start step already runs on the freshly loaded sample.
  assign mod_sample = blk_start ? (buf_full_q ? buf_q : '0) : cur_q;

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q    <= '0;
      step_q     <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      if (blk_start && !buf_full_q) underrun_q <= 1'b1;
      if (!i_enable) begin
        presc_q <= '0;
        step_q  <= '0;
      end else begin
        presc_q <= strobe ? '0 : presc_q + 1'b1;
        if (strobe) step_q <= (step_q == SW'(OSR - 1)) ? '0 : step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (xfer)      buf_q <= i_sample;
    if (blk_start) cur_q <= mod_sample;
  end

`ifdef CS_DRV_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset)     lfsr_q <= LFSR_SEED;
    else if (strobe) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign dith = lfsr_q[0];
`else
  assign dith = 1'b0;
`endif

  sd_mod1 #(.W(W)) u_mod (
    .clk_i    (i_sys_clk),
    .rst_i    (i_reset),
    .clr_i    (!i_enable),
    .strobe_i (strobe),
    .sample_i (mod_sample),
    .dith_i   (dith),
    .bit_o    (mod_bit)
  );

  // A polarity change always passes through ST_DEAD with both branches off.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_OFF;
      target_q <= ST_OFF;
      dead_q   <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else if (!i_enable) begin
      state_q <= ST_OFF;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: if (strobe) begin
          state_q <= mod_bit ? ST_HI : ST_LO;
          hi_q    <= mod_bit;
          lo_q    <= !mod_bit;
        end
        ST_HI: if (strobe && !mod_bit) begin
          state_q  <= ST_DEAD;
          target_q <= ST_LO;
          dead_q   <= DW'(DEAD_CYC - 1);
          hi_q     <= 1'b0;
        end
        ST_LO: if (strobe && mod_bit) begin
          state_q  <= ST_DEAD;
          target_q <= ST_HI;
          dead_q   <= DW'(DEAD_CYC - 1);
          lo_q     <= 1'b0;
        end
        ST_DEAD: begin
          if (dead_q == '0) begin
            state_q <= target_q;
            hi_q    <= (target_q == ST_HI);
            lo_q    <= (target_q == ST_LO);
          end else begin
            dead_q <= dead_q - 1'b1;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign o_sample_ready = !buf_full_q;
  assign o_cs_cell_hi   = hi_q;
  assign o_cs_cell_lo   = lo_q;
  assign o_underrun     = underrun_q;

endmodule
